// File: rtl/psum_drain.sv
// psum_drain: snapshots all PE partial sums on a start rise and streams them out over valid/ready.
module psum_drain #(
  parameter int NUM_PE = 16,
  parameter int PSUM_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     clk,
  input  logic                     rstSys,
  input  logic                     start_check,
  input  logic [NUM_PE*PSUM_W-1:0] psumIn,
  input  logic                     outReady,
  input  logic                     clrErr,
  output logic                     outValid,
  output logic [PSUM_W-1:0]        outData,
  output logic [IDX_W-1:0]         outIdx,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              start_q, overrun_q, overrun_d;
  logic [PSUM_W-1:0] bank_q [NUM_PE];
  logic [PSUM_W-1:0] bank_d [NUM_PE];
  logic              start_edge, last;
  assign start_edge = start_check & ~start_q;
  assign last       = idx_q == IDX_W'(NUM_PE - 1);
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bank_d    = bank_q;
    // an edge arriving mid-drain is dropped but flagged; set beats clear
    overrun_d = (overrun_q & ~clrErr) | (start_edge & (state_q != IDLE));
    if (state_q == IDLE && start_edge) begin
      state_d = SEND;
      idx_d   = '0;
      for (int i = 0; i < NUM_PE; i++) bank_d[i] = psumIn[i*PSUM_W +: PSUM_W];
    end else if (state_q == SEND && outReady) begin
      state_d = last ? DONE : SEND;
      idx_d   = last ? idx_q : idx_q + IDX_W'(1);
    end else if (state_q != IDLE && state_q != SEND) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rstSys) begin
    if (rstSys) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) bank_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      start_q   <= start_check;
      overrun_q <= overrun_d;
      bank_q    <= bank_d;
    end
  end
  assign outValid = state_q == SEND;
  assign outData  = outValid ? bank_q[idx_q] : '0;
  assign outIdx   = outValid ? idx_q : '0;
  assign busy     = state_q == SEND || state_q == DONE;
  assign done     = state_q == DONE;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed + randomized checks of psum_drain against a snapshot/queue reference model.
module tb_psum_drain;
  logic         clk = 0, rstSys = 1, start_check = 0, outReady = 0, clrErr = 0;
  logic [255:0] psumIn = '0;
  logic         outValid, busy, done, overrun;
  logic [15:0]  outData;
  logic [3:0]   outIdx;
  logic [15:0]  snap [16];
  int           checks = 0, errors = 0;
  bit           exp_ovr = 0;

  psum_drain dut (
    .clk(clk), .rstSys(rstSys), .start_check(start_check), .psumIn(psumIn),
    .outReady(outReady), .clrErr(clrErr), .outValid(outValid), .outData(outData),
    .outIdx(outIdx), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, outValid, 0);
    chk({tag, "_data"}, outData, 0);
    chk({tag, "_idx"}, outIdx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovr"}, overrun, exp_ovr);
  endtask

  task automatic trigger(input bit hold);
    for (int k = 0; k < 16; k++) snap[k] = psumIn[k*16 +: 16];
    start_check = 1;
    tick();
    if (!hold) start_check = 0;
  endtask

  // Expects words snap[0..15] in order, accepting only on ready; then one done cycle, then idle.
  task automatic drain(input int stall_at, input bit rnd, input int restart_at, input bit clr_too, input bit corrupt);
    int  k = 0, stall = 0, budget = 300;
    bit  rdy, restarted = 0, pend = 0;
    while (k < 16 && budget > 0) begin
      chk("valid", outValid, 1);
      chk("data", outData, snap[k]);
      chk("idx", outIdx, k);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("ovr", overrun, exp_ovr);
      if (k == restart_at && !restarted) begin
        start_check = 1;
        clrErr = clr_too;
        restarted = 1;
        pend = 1;
      end
      if (k == stall_at && stall < 3) begin
        rdy = 0;
        stall++;
      end else rdy = rnd ? 1'($urandom % 2) : 1'b1;
      outReady = rdy;
      if (corrupt) psumIn = '1;
      tick();
      if (pend) begin
        start_check = 0;
        clrErr = 0;
        exp_ovr = 1;
        pend = 0;
      end
      if (rdy) k++;
      budget--;
    end
    if (budget == 0) chk("drain_timeout", k, 16);
    chk("done_pulse", done, 1);
    chk("done_valid", outValid, 0);
    chk("done_busy", busy, 1);
    chk("done_data", outData, 0);
    tick();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_valid", outValid, 0);
  endtask

  initial begin
    tick();
    chk_idle("reset");
    tick();
    rstSys = 0;
    tick();
    chk_idle("post_reset");

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'h0100 + 16'(k);
    trigger(0);
    drain(-1, 0, -1, 0, 0);
    chk_idle("full_idle");

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(0);
    drain(7, 0, -1, 0, 0);

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(0);
    drain(-1, 1, -1, 0, 1);

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(0);
    drain(-1, 0, 3, 0, 0);
    repeat (4) begin
      tick();
      chk_idle("no_second_burst");
    end

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(0);
    drain(-1, 1, 5, 1, 0);
    chk("ovr_set_wins", overrun, 1);

    clrErr = 1;
    tick();
    clrErr = 0;
    exp_ovr = 0;
    chk_idle("clr_err");

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(1);
    drain(-1, 0, -1, 0, 0);
    repeat (21) begin
      tick();
      chk_idle("level_hold");
    end
    start_check = 0;
    tick();
    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(0);
    drain(-1, 1, -1, 0, 0);
    chk("level_ovr", overrun, 0);

    for (int k = 0; k < 16; k++) psumIn[k*16 +: 16] = 16'($urandom);
    trigger(0);
    outReady = 1;
    repeat (5) tick();
    chk("pre_rst_idx", outIdx, 5);
    chk("pre_rst_valid", outValid, 1);
    #2 rstSys = 1;
    #1;
    chk_idle("async_rst");
    tick();
    rstSys = 0;
    repeat (5) begin
      tick();
      chk_idle("after_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/psum_drain.md
# psum_drain

Result-drain unit at the output end of the 4x4 output-stationary systolic array. It consumes the `start_check` indication from `CTRL` and snapshots all per-PE partial sums in one cycle. It then streams them out one word per accepted beat on a valid/ready interface. This frees the array to begin its next computation while the results are being read.

## Interface
- `NUM_PE`, default 16: number of PEs; also the number of words per drain burst.
- `PSUM_W`, default 16: width of each PE partial sum.
- `IDX_W`, default 4: width of the word index; must satisfy 2^IDX_W >= NUM_PE.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstSys`  in  1  asynchronous, active-high reset.
- `start_check`  in  1  results-ready level from `CTRL`; only its rising edge is used.
- `psumIn`  in  NUM_PE*PSUM_W  flattened PE accumulators; PE k is at bits [k*PSUM_W +: PSUM_W].
- `outReady`  in  1  downstream accepts a word.
- `clrErr`  in  1  synchronous clear of `overrun`.
- `outValid`  out  1  `outData` and `outIdx` are valid.
- `outData`  out  PSUM_W  current partial sum.
- `outIdx`  out  IDX_W  PE index of `outData`.
- `busy`  out  1  drain in progress (high in SEND and DONE).
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `overrun`  out  1  sticky flag: a new result arrived while a drain was in progress.

## Operation
- Edge detect:
  - A `startQ` register holds the previous value of `start_check`; it resets to 0.
  - `startEdge = start_check & ~startQ`.
- FSM states:
  - **IDLE**
    - On `startEdge`, capture all `psumIn` words into the shadow bank, set idx=0, and go to SEND.
    - Otherwise, hold.
  - **SEND**
    - `outValid`=1, `outData`=bank[idx], `outIdx`=idx.
    - On a handshake (`outValid & outReady`):
      - If idx==NUM_PE-1, go to DONE.
      - Otherwise, idx increments.
    - Without a handshake, all outputs hold stable. Once `outValid` is asserted, it never drops before acceptance.
  - **DONE**
    - `done`=1 for exactly one cycle, `outValid`=0; go to IDLE.
- The shadow bank is written only on the IDLE capture. Changes on `psumIn` during SEND do not affect the output.
- Overrun:
  - `startEdge` in SEND or DONE sets `overrun`, and that edge is discarded (no capture, no queued drain).
  - `clrErr` clears `overrun`.
  - If `clrErr` and an overrun-setting edge occur in the same cycle, set wins.
- The index counter has no wrap-around: it never exceeds NUM_PE-1. idx resets to 0 on every capture.
- Reset (async assert, any state):
  - State goes to IDLE. idx, `startQ`, `overrun` and the shadow bank clear to 0.
  - All outputs go to 0: `outValid`, `outData`, `outIdx`, `busy`, `done`, `overrun`.
  - A drain in progress is abandoned; no `done` pulse is produced.
- `outData` is driven from the bank mux only in SEND; it is 0 in IDLE and DONE.

## Timing
- `start_check` rises before edge N (sampled high at edge N, with `startQ`=0): capture and SEND entry happen at edge N. `outValid`=1 and `outIdx`=0 from cycle N+1.
- Throughput with `outReady` held at 1: one word per cycle. Words 0..NUM_PE-1 appear on cycles N+1..N+NUM_PE.
- `done` is high on cycle N+NUM_PE+1; `busy` drops in cycle N+NUM_PE+2.
- Minimum spacing between accepted `startEdge`s is NUM_PE+2 cycles. An edge sampled while in DONE counts as an overrun.
- If `start_check` stays high, no re-trigger occurs; it must fall and rise again.
- All outputs are registered or decoded from registered state. There are no combinational paths from `outReady` or `start_check` to any output.

## Test plan
- **Reset:**
  - Assert `rstSys` mid-SEND at idx=5: all outputs go to 0 immediately.
  - After release, `outValid` stays 0 until a new `start_check` rise.
- **Full drain:**
  - Set psumIn word k = 16'h0100+k, then pulse `start_check`, with `outReady`=1.
  - Expect 16 consecutive beats with outData 0x0100..0x010F and outIdx 0..15, then `done`=1 for one cycle.
- **Backpressure:**
  - Hold `outReady`=0 for 3 cycles at idx=7.
  - `outData`/`outIdx` hold at word 7 with `outValid`=1. The sequence then resumes at 8 with no loss or duplication.
- **Snapshot isolation:** change `psumIn` to all 0xFFFF during SEND; the streamed words still equal the captured values.
- **Overrun:**
  - Raise `start_check` a second time at idx=3: `overrun`=1 and the current drain completes unchanged, with no second burst.
  - Assert `clrErr` and `start_check` rise together while busy: `overrun` stays 1.
- **Level hold:**
  - Keep `start_check` high for 40 cycles: exactly one burst of 16 words.
  - Lower it, raise it again in IDLE: a second burst occurs and `overrun`=0.
